// File: rtl/inst_fetch.sv
// Instruction fetch stage: PC generation, credit-limited word reads over req/gnt/rvalid,
// and a small registered instruction FIFO handed to decode with a valid/ready handshake.
module inst_fetch #(
  parameter int                    ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0,
  parameter int                    FIFO_DEPTH = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic                  mem_req,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic                  mem_gnt,
  input  logic                  mem_rvalid,
  input  logic [31:0]           mem_rdata,
  input  logic                  redirect,
  input  logic [ADDR_WIDTH-1:0] redirect_pc,
  output logic                  id_valid,
  output logic [ADDR_WIDTH-1:0] id_pc,
  output logic [31:0]           id_inst,
  input  logic                  id_ready
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int SW = CW + 1;

  logic [ADDR_WIDTH-1:0] r_fetchPc;
  logic [CW-1:0]         r_outstanding;
  logic [CW-1:0]         r_killCnt;
  logic [CW-1:0]         r_count;
  logic [PW-1:0]         r_rdPtr;
  logic [PW-1:0]         r_wrPtr;
  logic [ADDR_WIDTH-1:0] r_fifoPc   [FIFO_DEPTH];
  logic [31:0]           r_fifoInst [FIFO_DEPTH];

  logic                  w_pop;
  logic [SW-1:0]         w_sum;
  logic                  w_issue;
  logic                  w_rsp;
  logic                  w_kill;
  logic                  w_push;
  logic [ADDR_WIDTH-1:0] w_rspPc;
  logic [CW-1:0]         w_outNext;
  logic                  w_unused;

  assign w_unused = ^redirect_pc[1:0];

  // Every outstanding request owns a FIFO slot, so the buffer can never overflow.
  assign w_pop     = id_valid & id_ready;
  assign w_sum     = SW'(r_outstanding) + SW'(r_count) - SW'(w_pop);
  assign mem_req   = rst & (w_sum < SW'(FIFO_DEPTH));
  assign mem_addr  = rst ? r_fetchPc : RESET_PC;
  assign w_issue   = mem_req & mem_gnt;

  assign w_rsp     = mem_rvalid & (r_outstanding != '0);
  assign w_kill    = w_rsp & (r_killCnt != '0);
  assign w_push    = w_rsp & ~w_kill;
  assign w_outNext = r_outstanding + CW'(w_issue) - CW'(w_rsp);

  // Once the killed responses are gone, all in-flight requests are sequential up to fetchPc.
  assign w_rspPc   = r_fetchPc - (ADDR_WIDTH'(r_outstanding) << 2);

  assign id_valid  = rst & (r_count != '0);
  assign id_pc     = id_valid ? r_fifoPc[r_rdPtr]   : '0;
  assign id_inst   = id_valid ? r_fifoInst[r_rdPtr] : '0;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_fetchPc     <= RESET_PC;
      r_outstanding <= '0;
      r_killCnt     <= '0;
      r_count       <= '0;
      r_rdPtr       <= '0;
      r_wrPtr       <= '0;
    end else begin
      r_outstanding <= w_outNext;
      if (redirect) begin
        r_fetchPc <= {redirect_pc[ADDR_WIDTH-1:2], 2'b00};
        r_killCnt <= w_outNext;
        r_count   <= '0;
        r_rdPtr   <= '0;
        r_wrPtr   <= '0;
      end else begin
        if (w_issue) r_fetchPc <= r_fetchPc + ADDR_WIDTH'(4);
        if (w_kill)  r_killCnt <= r_killCnt - CW'(1);
        if (w_push)  r_wrPtr   <= r_wrPtr + PW'(1);
        if (w_pop)   r_rdPtr   <= r_rdPtr + PW'(1);
        r_count <= r_count + CW'(w_push) - CW'(w_pop);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst && w_push && !redirect) begin
      r_fifoPc[r_wrPtr]   <= w_rspPc;
      r_fifoInst[r_wrPtr] <= mem_rdata;
    end
  end

endmodule

// File: tb/tb_inst_fetch.sv
// Bench for inst_fetch: an in-order RAM plus a stream-level model of which PCs decode must
// see, how many instructions are buffered, and when a fetch request is allowed.
module tb_inst_fetch;

  localparam int          AW       = 32;
  localparam int          DEPTH    = 2;
  localparam logic [31:0] RESET_PC = 32'h0;

  logic        clk = 1'b0;
  logic        rst;
  logic        memReq;
  logic [31:0] memAddr;
  logic        memGnt;
  logic        memRvalid;
  logic [31:0] memRdata;
  logic        redirect;
  logic [31:0] redirectPc;
  logic        idValid;
  logic [31:0] idPc;
  logic [31:0] idInst;
  logic        idReady;

  inst_fetch #(.ADDR_WIDTH(AW), .RESET_PC(RESET_PC), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .mem_req(memReq), .mem_addr(memAddr), .mem_gnt(memGnt),
    .mem_rvalid(memRvalid), .mem_rdata(memRdata),
    .redirect(redirect), .redirect_pc(redirectPc),
    .id_valid(idValid), .id_pc(idPc), .id_inst(idInst), .id_ready(idReady)
  );

  always #5 clk = ~clk;

  int          assertCount = 0;
  int          failCount   = 0;
  logic [31:0] romWords [4] = '{32'h34011100, 32'h34020020, 32'h3403ff00, 32'h3404ffff};

  logic [31:0] pendAddr [$];
  bit          pendStale [$];
  logic [31:0] expFetch;
  logic [31:0] expPc;
  int          occ;

  bit          lastPopped;
  logic [31:0] lastPopPc;
  logic [31:0] lastPopInst;
  bit          lastGrant;
  logic        lastReq;
  logic [31:0] lastAddr;

  function automatic logic [31:0] ramWord(input logic [31:0] a);
    if (a < 32'h10) return romWords[a[3:2]];
    return (a * 32'h9E37_79B1) ^ 32'h1357_9BDF;
  endfunction

  function automatic void modelReset();
    pendAddr.delete();
    pendStale.delete();
    expFetch = RESET_PC;
    expPc    = RESET_PC;
    occ      = 0;
  endfunction

  // One clock: drive inputs, check outputs against the model, then advance the model past the edge.
  task automatic applyStimulus(input bit ready, input bit gnt, input bit rvOk,
                               input bit redir, input logic [31:0] rpc);
    bit          rv;
    bit          pop;
    bit          expReq;
    bit          expValid;
    bit          stale;
    logic [31:0] expAddr;
    idReady    = ready;
    memGnt     = gnt;
    redirect   = redir;
    redirectPc = rpc;
    rv         = rvOk && (pendAddr.size() > 0);
    memRvalid  = rv;
    memRdata   = rv ? ramWord(pendAddr[0]) : $urandom;
    #1;
    expValid = rst && (occ > 0);
    pop      = expValid && ready;
    expReq   = rst && ((pendAddr.size() + occ - int'(pop)) < DEPTH);
    expAddr  = rst ? expFetch : RESET_PC;
    lastPopped = 1'b0;
    lastReq    = memReq;
    lastAddr   = memAddr;
    lastGrant  = memReq && gnt;

    assertCount++;
    if (memReq !== expReq) begin
      failCount++;
      $display("[TB] FAIL mem_req: got %b, expected %b (t=%0t)", memReq, expReq, $time);
    end
    assertCount++;
    if (memAddr !== expAddr) begin
      failCount++;
      $display("[TB] FAIL mem_addr: got %h, expected %h (t=%0t)", memAddr, expAddr, $time);
    end
    assertCount++;
    if (idValid !== expValid) begin
      failCount++;
      $display("[TB] FAIL id_valid: got %b, expected %b (t=%0t)", idValid, expValid, $time);
    end
    if (expValid) begin
      assertCount++;
      if (idPc !== expPc || idInst !== ramWord(expPc)) begin
        failCount++;
        $display("[TB] FAIL id_head: got pc=%h inst=%h, expected pc=%h inst=%h (t=%0t)",
                 idPc, idInst, expPc, ramWord(expPc), $time);
      end
    end
    if (!rst) begin
      assertCount++;
      if (idPc !== 32'h0 || idInst !== 32'h0) begin
        failCount++;
        $display("[TB] FAIL reset_id_out: got pc=%h inst=%h, expected 0/0", idPc, idInst);
      end
    end

    if (rst) begin
      if (rv) begin
        stale = pendStale.pop_front();
        void'(pendAddr.pop_front());
        if (!stale) occ++;
      end
      if (pop) begin
        lastPopped  = 1'b1;
        lastPopPc   = idPc;
        lastPopInst = idInst;
        expPc       = expPc + 32'd4;
        occ--;
      end
      if (expReq && gnt) begin
        pendAddr.push_back(expFetch);
        pendStale.push_back(1'b0);
        expFetch = expFetch + 32'd4;
      end
      if (redir) begin
        foreach (pendStale[i]) pendStale[i] = 1'b1;
        occ      = 0;
        expFetch = rpc & ~32'h3;
        expPc    = rpc & ~32'h3;
      end
    end
    @(posedge clk);
    if (!rst) modelReset();
    @(negedge clk);
  endtask

  task automatic doReset(input int n);
    rst = 1'b0;
    for (int i = 0; i < n; i++) applyStimulus(1, 1, 1, 0, 32'h0);
    rst = 1'b1;
  endtask

  task automatic test_reset();
    doReset(10);
    for (int k = 0; k < 8; k++) begin
      applyStimulus(1, 1, 1, 0, 32'h0);
      if (k >= 2 && k <= 5) begin
        assertCount++;
        if (!lastPopped || lastPopPc !== 32'(4 * (k - 2)) || lastPopInst !== romWords[k - 2]) begin
          failCount++;
          $display("[TB] FAIL startup_cycle%0d: got popped=%0d pc=%h inst=%h, expected pc=%h inst=%h",
                   k, lastPopped, lastPopPc, lastPopInst, 32'(4 * (k - 2)), romWords[k - 2]);
        end
      end
    end
  endtask

  task automatic test_backpressure();
    int grants;
    doReset(2);
    grants = 0;
    for (int i = 0; i < 6; i++) begin
      applyStimulus(0, 1, 1, 0, 32'h0);
      grants += int'(lastGrant);
    end
    assertCount++;
    if (grants > DEPTH) begin
      failCount++;
      $display("[TB] FAIL backpressure_grants: got %0d, expected at most %0d", grants, DEPTH);
    end
    assertCount++;
    if (lastReq !== 1'b0) begin
      failCount++;
      $display("[TB] FAIL backpressure_req: got %b, expected 0", lastReq);
    end
    assertCount++;
    if (idPc !== 32'h0 || idInst !== 32'h34011100) begin
      failCount++;
      $display("[TB] FAIL backpressure_head: got pc=%h inst=%h, expected 0/34011100", idPc, idInst);
    end
    for (int i = 0; i < 10; i++) applyStimulus(1, 1, 1, 0, 32'h0);
  endtask

  task automatic test_wait_states();
    doReset(2);
    applyStimulus(1, 1, 1, 0, 32'h0);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1, 0, 1, 0, 32'h0);
      assertCount++;
      if (lastReq !== 1'b1 || lastAddr !== 32'h4) begin
        failCount++;
        $display("[TB] FAIL wait_state%0d: got req=%b addr=%h, expected 1/00000004", i, lastReq, lastAddr);
      end
    end
    for (int i = 0; i < 10; i++) applyStimulus(1, 1, 1, 0, 32'h0);
  endtask

  task automatic test_redirect_inflight();
    bit seen;
    doReset(2);
    applyStimulus(1, 1, 0, 0, 32'h0);
    applyStimulus(1, 1, 0, 0, 32'h0);
    applyStimulus(1, 1, 0, 1, 32'h102);
    applyStimulus(1, 1, 1, 0, 32'h0);
    assertCount++;
    if (lastAddr !== 32'h100) begin
      failCount++;
      $display("[TB] FAIL redirect_addr: got %h, expected 00000100", lastAddr);
    end
    seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      applyStimulus(1, 1, 1, 0, 32'h0);
      if (lastPopped && !seen) begin
        seen = 1'b1;
        assertCount++;
        if (lastPopPc !== 32'h100) begin
          failCount++;
          $display("[TB] FAIL redirect_first_pc: got %h, expected 00000100", lastPopPc);
        end
      end
    end
    if (!seen) begin
      assertCount++;
      failCount++;
      $display("[TB] FAIL redirect_timeout: got no instruction, expected pc 00000100");
    end
  endtask

  task automatic test_redirect_coincident();
    bit seen;
    doReset(2);
    for (int i = 0; i < 4; i++) applyStimulus(1, 1, 1, 0, 32'h0);
    applyStimulus(1, 1, 1, 1, 32'h0000_0203);
    assertCount++;
    if (!lastGrant) begin
      failCount++;
      $display("[TB] FAIL coincident_grant: got req=%b, expected 1", lastReq);
    end
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1, 1, 1, 0, 32'h0);
      if (lastPopped && !seen) begin
        seen = 1'b1;
        assertCount++;
        if (lastPopPc !== 32'h200) begin
          failCount++;
          $display("[TB] FAIL coincident_first_pc: got %h, expected 00000200", lastPopPc);
        end
      end
    end
    if (!seen) begin
      assertCount++;
      failCount++;
      $display("[TB] FAIL coincident_timeout: got no instruction, expected pc 00000200");
    end
    // PC wraps past the top of the address space back into the boot words
    applyStimulus(1, 1, 1, 1, 32'hFFFF_FFFA);
    for (int i = 0; i < 10; i++) applyStimulus(1, 1, 1, 0, 32'h0);
  endtask

  task automatic test_reset_midstream();
    doReset(2);
    for (int k = 0; k < 15; k++) begin
      rst = (k != 7);
      applyStimulus(1, 1, 1, 0, 32'h0);
      if (k == 8) begin
        assertCount++;
        if (lastAddr !== RESET_PC || lastReq !== 1'b1) begin
          failCount++;
          $display("[TB] FAIL midreset_restart: got req=%b addr=%h, expected 1/%h", lastReq, lastAddr, RESET_PC);
        end
      end
      if (k == 10) begin
        assertCount++;
        if (!lastPopped || lastPopPc !== RESET_PC || lastPopInst !== romWords[0]) begin
          failCount++;
          $display("[TB] FAIL midreset_first: got popped=%0d pc=%h inst=%h, expected pc=%h inst=%h",
                   lastPopped, lastPopPc, lastPopInst, RESET_PC, romWords[0]);
        end
      end
    end
  endtask

  task automatic test_random();
    logic [31:0] rpc;
    doReset(2);
    for (int i = 0; i < 3000; i++) begin
      rpc = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15))) : $urandom;
      rst = ($urandom_range(0, 199) != 0);
      applyStimulus($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
                    $urandom_range(0, 2) != 0, $urandom_range(0, 29) == 0, rpc);
    end
    rst = 1'b1;
    for (int i = 0; i < 10; i++) applyStimulus(1, 1, 1, 0, 32'h0);
  endtask

  initial begin
    rst        = 1'b0;
    idReady    = 1'b0;
    memGnt     = 1'b0;
    memRvalid  = 1'b0;
    memRdata   = 32'h0;
    redirect   = 1'b0;
    redirectPc = 32'h0;
    modelReset();
    test_reset();
    test_backpressure();
    test_wait_states();
    test_redirect_inflight();
    test_redirect_coincident();
    test_reset_midstream();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
